fu_ls_agu_buf: RTL and testbench

// Parametrised load/store FU: DEPTH-entry in-order buffer between RS dispatch and the LSQ. Entries capture base/data

---
 rtl/fu_ls_agu_buf_pkg.sv | 47 ++++
 rtl/fu_ls_agu_buf_align.sv | 29 ++
 rtl/fu_ls_agu_buf.sv | 239 +++++++++++++++++++++++
 tb/tb_fu_ls_agu_buf.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fu_ls_agu_buf_pkg.sv
// Shared types for the load/store AGU buffer: access size, entry layout,
// head-FSM states and the alignment rule used to suppress LSQ requests.
package ls_pkg;

  localparam int unsigned LS_XLEN  = 32;
  localparam int unsigned LS_TAG_W = 6;
  localparam int unsigned LS_SQ_W  = 3;

  typedef enum logic [1:0] {
    LS_BYTE = 2'd0,
    LS_HALF = 2'd1,
    LS_WORD = 2'd2
  } LS_SIZE;

  typedef enum logic [1:0] {
    H_WAIT = 2'd0,
    H_REQ  = 2'd1,
    H_RSP  = 2'd2
  } HEAD_STATE;

  // Entry widths follow the package localparams; the top-level parameter
  // defaults are kept equal to them.
  typedef struct packed {
    logic                valid;
    logic                load;
    logic [LS_XLEN-1:0]  base;
    logic                base_ok;
    logic [LS_TAG_W-1:0] base_tag;
    logic [LS_XLEN-1:0]  data;
    logic                data_ok;
    logic [LS_TAG_W-1:0] data_tag;
    logic [LS_XLEN-1:0]  imm;
    LS_SIZE              size;
    logic                is_unsigned;
    logic [LS_SQ_W-1:0]  sq_pos;
    logic [LS_TAG_W-1:0] tag;
  } LS_ENTRY;

  function automatic logic misaligned(input LS_SIZE size, input logic [1:0] addr_lo);
    case (size)
      LS_HALF: return addr_lo[0];
      LS_WORD: return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fu_ls_agu_buf_align.sv
// Load data alignment: selects the byte/half lane of the returned aligned
// word and sign- or zero-extends it to XLEN.
module ls_load_align
  import ls_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [1:0]      addr_lo,
  input  LS_SIZE          size,
  input  logic            is_unsigned,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] value
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane select followed by extension according to access size.
  always_comb begin
    byte_lane = word[{addr_lo, 3'b000} +: 8];
    half_lane = addr_lo[1] ? word[31:16] : word[15:0];
    case (size)
      LS_BYTE: value = {{(XLEN-8){~is_unsigned & byte_lane[7]}}, byte_lane};
      LS_HALF: value = {{(XLEN-16){~is_unsigned & half_lane[15]}}, half_lane};
      default: value = word;
    endcase
  end

endmodule

// File: rtl/fu_ls_agu_buf.sv
// Load/store functional unit: in-order buffer between dispatch and the LSQ.
// Entries capture operands at dispatch or later from the CDB; the head forms
// base+imm, issues to the LSQ and reports completion on registered res_* outputs.
module fu_ls_agu_buf
  import ls_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned LSQ_IDX_LEN = 3,
  parameter int unsigned TAG_W       = 6
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   squash,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic                   issue_load,
  input  logic                   issue_store,
  input  logic [XLEN-1:0]        issue_base,
  input  logic                   issue_base_ok,
  input  logic [TAG_W-1:0]       issue_base_tag,
  input  logic [XLEN-1:0]        issue_data,
  input  logic                   issue_data_ok,
  input  logic [TAG_W-1:0]       issue_data_tag,
  input  logic [XLEN-1:0]        issue_imm,
  input  logic [1:0]             issue_size,
  input  logic                   issue_unsigned,
  input  logic [LSQ_IDX_LEN-1:0] issue_sq_pos,
  input  logic [TAG_W-1:0]       issue_tag,
  input  logic                   cdb_valid,
  input  logic [TAG_W-1:0]       cdb_tag,
  input  logic [XLEN-1:0]        cdb_value,
  output logic                   lsq_req_valid,
  input  logic                   lsq_req_ready,
  output logic                   lsq_req_load,
  output logic                   lsq_req_store,
  output logic [XLEN-1:0]        lsq_req_addr,
  output logic [XLEN-1:0]        lsq_req_data,
  output logic [1:0]             lsq_req_size,
  output logic [LSQ_IDX_LEN-1:0] lsq_req_sq_pos,
  input  logic                   lsq_rsp_valid,
  input  logic [XLEN-1:0]        lsq_rsp_data,
  output logic                   res_valid,
  output logic [TAG_W-1:0]       res_tag,
  output logic [XLEN-1:0]        res_value,
  output logic                   res_store,
  output logic                   res_misalign
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  LS_ENTRY          entries [DEPTH];
  LS_ENTRY          new_entry;
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [PTR_W:0]   count_q;
  HEAD_STATE        state_q;
  HEAD_STATE        state_d;
  HEAD_STATE        cur_state;

  logic             enq;
  logic             pop;
  logic             fire;
  logic             req_valid;
  logic             head_rdy;
  logic             head_mis;
  logic [XLEN-1:0]  addr;
  logic [XLEN-1:0]  load_value;
  logic [XLEN-1:0]  res_value_d;
  logic             res_store_d;
  logic             res_mis_d;

  // A load/store that is flagged as both is handled as a load, so only
  // issue_load decides the entry kind.
  logic unused_store;
  assign unused_store = issue_store;

  assign issue_ready = (count_q != (PTR_W+1)'(DEPTH));
  assign enq         = issue_valid && issue_ready;

  assign addr     = entries[head_q].base + entries[head_q].imm;
  assign head_rdy = entries[head_q].valid && entries[head_q].base_ok && entries[head_q].data_ok;
  assign head_mis = misaligned(entries[head_q].size, addr[1:0]);

  ls_load_align #(.XLEN(XLEN)) u_align (
    .addr_lo     (addr[1:0]),
    .size        (entries[head_q].size),
    .is_unsigned (entries[head_q].is_unsigned),
    .word        (lsq_rsp_data),
    .value       (load_value)
  );

  // Build the incoming entry, taking a same-cycle CDB broadcast for pending operands.
  always_comb begin
    new_entry             = '0;
    new_entry.valid       = 1'b1;
    new_entry.load        = issue_load;
    new_entry.base        = issue_base;
    new_entry.base_ok     = issue_base_ok;
    new_entry.base_tag    = issue_base_tag;
    new_entry.data        = issue_data;
    new_entry.data_ok     = issue_load | issue_data_ok;
    new_entry.data_tag    = issue_data_tag;
    new_entry.imm         = issue_imm;
    new_entry.size        = LS_SIZE'(issue_size);
    new_entry.is_unsigned = issue_unsigned;
    new_entry.sq_pos      = issue_sq_pos;
    new_entry.tag         = issue_tag;
    if (!new_entry.base_ok && cdb_valid && cdb_tag == issue_base_tag) begin
      new_entry.base    = cdb_value;
      new_entry.base_ok = 1'b1;
    end
    if (!new_entry.data_ok && cdb_valid && cdb_tag == issue_data_tag) begin
      new_entry.data    = cdb_value;
      new_entry.data_ok = 1'b1;
    end
  end

  // Entry storage: CDB snoop on resident entries, enqueue at tail, retire at head.
  always_ff @(posedge clock) begin
    if (reset || squash) begin
      for (int unsigned i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (entries[i].valid) begin
          if (!entries[i].base_ok && cdb_valid && cdb_tag == entries[i].base_tag) begin
            entries[i].base    <= cdb_value;
            entries[i].base_ok <= 1'b1;
          end
          if (!entries[i].data_ok && cdb_valid && cdb_tag == entries[i].data_tag) begin
            entries[i].data    <= cdb_value;
            entries[i].data_ok <= 1'b1;
          end
        end
        if (enq && tail_q == PTR_W'(i)) begin
          entries[i] <= new_entry;
        end else if (pop && head_q == PTR_W'(i)) begin
          entries[i].valid <= 1'b0;
        end
      end
    end
  end

  // Queue pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset || squash) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq) tail_q <= tail_q + PTR_W'(1);
      if (pop) head_q <= head_q + PTR_W'(1);
      count_q <= count_q + (PTR_W+1)'(enq) - (PTR_W+1)'(pop);
    end
  end

  // Head FSM state register.
  always_ff @(posedge clock) begin
    if (reset || squash) state_q <= H_WAIT;
    else                 state_q <= state_d;
  end

  // Head FSM next-state and request/completion decode. H_WAIT falls through
  // to H_REQ in the same cycle the head operands are ready, so a ready op
  // requests the cycle after dispatch.
  always_comb begin
    state_d     = state_q;
    cur_state   = state_q;
    req_valid   = 1'b0;
    pop         = 1'b0;
    fire        = 1'b0;
    res_value_d = '0;
    res_store_d = 1'b0;
    res_mis_d   = 1'b0;
    if (state_q == H_WAIT && head_rdy) cur_state = H_REQ;
    case (cur_state)
      H_REQ: begin
        if (head_mis) begin
          fire        = 1'b1;
          pop         = 1'b1;
          res_mis_d   = 1'b1;
          res_store_d = !entries[head_q].load;
          state_d     = H_WAIT;
        end else begin
          req_valid = 1'b1;
          state_d   = H_REQ;
          if (lsq_req_ready) begin
            if (entries[head_q].load) begin
              state_d = H_RSP;
            end else begin
              fire        = 1'b1;
              pop         = 1'b1;
              res_store_d = 1'b1;
              state_d     = H_WAIT;
            end
          end
        end
      end
      H_RSP: begin
        if (lsq_rsp_valid) begin
          fire        = 1'b1;
          pop         = 1'b1;
          res_value_d = load_value;
          state_d     = H_WAIT;
        end
      end
      default: state_d = H_WAIT;
    endcase
  end

  // Request fields are zero whenever no request is presented.
  always_comb begin
    lsq_req_valid  = req_valid;
    lsq_req_load   = req_valid && entries[head_q].load;
    lsq_req_store  = req_valid && !entries[head_q].load;
    lsq_req_addr   = req_valid ? addr : '0;
    lsq_req_data   = (req_valid && !entries[head_q].load) ? entries[head_q].data : '0;
    lsq_req_size   = req_valid ? entries[head_q].size : 2'd0;
    lsq_req_sq_pos = req_valid ? entries[head_q].sq_pos : '0;
  end

  // Registered single-cycle completion report.
  always_ff @(posedge clock) begin
    if (reset || squash) begin
      res_valid    <= 1'b0;
      res_tag      <= '0;
      res_value    <= '0;
      res_store    <= 1'b0;
      res_misalign <= 1'b0;
    end else begin
      res_valid    <= fire;
      res_tag      <= fire ? entries[head_q].tag : '0;
      res_value    <= fire ? res_value_d : '0;
      res_store    <= fire && res_store_d;
      res_misalign <= fire && res_mis_d;
    end
  end

endmodule

// File: tb/tb_fu_ls_agu_buf.sv
// Directed bench for fu_ls_agu_buf with a result scoreboard.
module tb_fu_ls_agu_buf;

  logic        clock = 1'b0;
  logic        reset, squash;
  logic        issue_valid, issue_ready, issue_load, issue_store;
  logic [31:0] issue_base, issue_data, issue_imm;
  logic        issue_base_ok, issue_data_ok, issue_unsigned;
  logic [5:0]  issue_base_tag, issue_data_tag, issue_tag;
  logic [1:0]  issue_size;
  logic [2:0]  issue_sq_pos;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        lsq_req_valid, lsq_req_ready, lsq_req_load, lsq_req_store;
  logic [31:0] lsq_req_addr, lsq_req_data;
  logic [1:0]  lsq_req_size;
  logic [2:0]  lsq_req_sq_pos;
  logic        lsq_rsp_valid;
  logic [31:0] lsq_rsp_data;
  logic        res_valid, res_store, res_misalign;
  logic [5:0]  res_tag;
  logic [31:0] res_value;

  typedef struct {
    logic [5:0]  tag;
    logic [31:0] value;
    logic        store;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;

  fu_ls_agu_buf #(.XLEN(32), .DEPTH(4), .LSQ_IDX_LEN(3), .TAG_W(6)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_load(issue_load), .issue_store(issue_store),
    .issue_base(issue_base), .issue_base_ok(issue_base_ok), .issue_base_tag(issue_base_tag),
    .issue_data(issue_data), .issue_data_ok(issue_data_ok), .issue_data_tag(issue_data_tag),
    .issue_imm(issue_imm), .issue_size(issue_size), .issue_unsigned(issue_unsigned),
    .issue_sq_pos(issue_sq_pos), .issue_tag(issue_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .lsq_req_valid(lsq_req_valid), .lsq_req_ready(lsq_req_ready),
    .lsq_req_load(lsq_req_load), .lsq_req_store(lsq_req_store),
    .lsq_req_addr(lsq_req_addr), .lsq_req_data(lsq_req_data),
    .lsq_req_size(lsq_req_size), .lsq_req_sq_pos(lsq_req_sq_pos),
    .lsq_rsp_valid(lsq_rsp_valid), .lsq_rsp_data(lsq_rsp_data),
    .res_valid(res_valid), .res_tag(res_tag), .res_value(res_value),
    .res_store(res_store), .res_misalign(res_misalign)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%h expected 0x%h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [5:0] tag, input logic [31:0] value, input logic store, input logic mis);
    exp_t e;
    e.tag = tag; e.value = value; e.store = store; e.mis = mis;
    sb.push_back(e);
  endtask

  task automatic issue(input logic ld, input logic [31:0] base, input logic bok, input logic [5:0] btag,
                       input logic [31:0] data, input logic dok, input logic [5:0] dtag,
                       input logic [31:0] imm, input logic [1:0] size, input logic uns,
                       input logic [2:0] sq, input logic [5:0] tag);
    issue_load = ld; issue_store = !ld;
    issue_base = base; issue_base_ok = bok; issue_base_tag = btag;
    issue_data = data; issue_data_ok = dok; issue_data_tag = dtag;
    issue_imm = imm; issue_size = size; issue_unsigned = uns;
    issue_sq_pos = sq; issue_tag = tag;
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
    cdb_valid = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (lsq_req_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(name, {31'b0, lsq_req_valid}, 32'd1);
  endtask

  task automatic serve_load(input logic [31:0] exp_addr, input logic [31:0] rsp);
    wait_req("req_wait");
    check("req_addr", lsq_req_addr, exp_addr);
    check("req_load", {31'b0, lsq_req_load}, 32'd1);
    lsq_req_ready = 1'b1;
    tick();
    lsq_req_ready = 1'b0;
    lsq_rsp_valid = 1'b1;
    lsq_rsp_data = rsp;
    tick();
    lsq_rsp_valid = 1'b0;
  endtask

  task automatic do_load(input logic [5:0] tag, input logic [31:0] base, input logic [31:0] imm,
                         input logic [1:0] size, input logic uns, input logic [31:0] exp_addr,
                         input logic [31:0] rsp, input logic [31:0] exp_val);
    push(tag, exp_val, 1'b0, 1'b0);
    issue(1'b1, base, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, imm, size, uns, 3'd0, tag);
    serve_load(exp_addr, rsp);
  endtask

  // Scoreboard: every completion must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (res_valid === 1'b1) begin
      compared++;
      assert (sb.size() > 0) else begin
        mismatched++;
        $error("FAIL res_unexpected: observed tag 0x%h expected no completion", res_tag);
      end
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("res_tag", {26'b0, res_tag}, {26'b0, e.tag});
        check("res_value", res_value, e.value);
        check("res_store", {31'b0, res_store}, {31'b0, e.store});
        check("res_misalign", {31'b0, res_misalign}, {31'b0, e.mis});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; squash = 1'b0; issue_valid = 1'b0; issue_load = 1'b0; issue_store = 1'b0;
    issue_base = '0; issue_base_ok = 1'b0; issue_base_tag = '0; issue_data = '0;
    issue_data_ok = 1'b0; issue_data_tag = '0; issue_imm = '0; issue_size = '0;
    issue_unsigned = 1'b0; issue_sq_pos = '0; issue_tag = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
    lsq_req_ready = 1'b0; lsq_rsp_valid = 1'b0; lsq_rsp_data = '0;
    tick(); tick();
    check("rst_issue_ready", {31'b0, issue_ready}, 32'd1);
    check("rst_req_valid", {31'b0, lsq_req_valid}, 32'd0);
    check("rst_res_valid", {31'b0, res_valid}, 32'd0);
    check("rst_req_addr", lsq_req_addr, 32'd0);
    reset = 1'b0;
    tick();

    // Word load, request visible the cycle after dispatch.
    push(6'd10, 32'hDEADBEEF, 1'b0, 1'b0);
    issue(1'b1, 32'h100, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd4, 2'd2, 1'b0, 3'd0, 6'd10);
    check("lw_req_next", {31'b0, lsq_req_valid}, 32'd1);
    check("lw_req_size", {30'b0, lsq_req_size}, 32'd2);
    serve_load(32'h104, 32'hDEADBEEF);

    // Sub-word extraction and extension.
    do_load(6'd11, 32'h100, 32'd3, 2'd0, 1'b0, 32'h103, 32'h80AABBCC, 32'hFFFFFF80);
    do_load(6'd12, 32'h100, 32'd3, 2'd0, 1'b1, 32'h103, 32'h80AABBCC, 32'h00000080);
    do_load(6'd13, 32'h100, 32'd2, 2'd1, 1'b0, 32'h102, 32'h80AABBCC, 32'hFFFF80AA);
    do_load(6'd14, 32'h100, 32'd0, 2'd1, 1'b1, 32'h100, 32'h80AABBCC, 32'h0000BBCC);
    do_load(6'd15, 32'h100, 32'd1, 2'd0, 1'b0, 32'h101, 32'h80AABBCC, 32'hFFFFFFBB);
    do_load(6'd16, 32'h200, 32'hFFFFFFFC, 2'd2, 1'b0, 32'h1FC, 32'h12345678, 32'h12345678);

    // Store waiting on CDB tag 5, then back-pressured for two cycles.
    issue(1'b0, 32'h300, 1'b1, 6'd0, 32'd0, 1'b0, 6'd5, 32'd8, 2'd2, 1'b0, 3'd3, 6'd20);
    check("st_wait_noreq", {31'b0, lsq_req_valid}, 32'd0);
    tick(); tick();
    cdb_valid = 1'b1; cdb_tag = 6'd5; cdb_value = 32'h55;
    tick();
    cdb_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("st_req_valid", {31'b0, lsq_req_valid}, 32'd1);
      check("st_req_store", {31'b0, lsq_req_store}, 32'd1);
      check("st_req_data", lsq_req_data, 32'h55);
      check("st_req_addr", lsq_req_addr, 32'h308);
      check("st_req_sq_pos", {29'b0, lsq_req_sq_pos}, 32'd3);
      if (k < 2) tick();
    end
    push(6'd20, 32'd0, 1'b1, 1'b0);
    lsq_req_ready = 1'b1;
    tick();
    lsq_req_ready = 1'b0;
    check("st_popped", {31'b0, lsq_req_valid}, 32'd0);
    tick();

    // Store data captured from a CDB broadcast in the dispatch cycle.
    cdb_valid = 1'b1; cdb_tag = 6'd7; cdb_value = 32'h77;
    issue(1'b0, 32'h40, 1'b1, 6'd0, 32'd0, 1'b0, 6'd7, 32'd0, 2'd2, 1'b0, 3'd1, 6'd21);
    check("byp_req_valid", {31'b0, lsq_req_valid}, 32'd1);
    check("byp_req_data", lsq_req_data, 32'h77);
    push(6'd21, 32'd0, 1'b1, 1'b0);
    lsq_req_ready = 1'b1;
    tick();
    lsq_req_ready = 1'b0;
    tick();

    // Fill to DEPTH, blocked issue, drain one, wrap the tail, drain in order.
    for (int k = 0; k < 4; k++) begin
      push(6'(30 + k), 32'hA0000000 + 32'(k), 1'b0, 1'b0);
      issue(1'b1, 32'h400, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'(4 * k), 2'd2, 1'b0, 3'd0, 6'(30 + k));
    end
    check("full_not_ready", {31'b0, issue_ready}, 32'd0);
    issue(1'b1, 32'h500, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0, 2'd2, 1'b0, 3'd0, 6'd40);
    check("full_still_blocked", {31'b0, issue_ready}, 32'd0);
    serve_load(32'h400, 32'hA0000000);
    check("drain_ready", {31'b0, issue_ready}, 32'd1);
    push(6'd34, 32'hA0000004, 1'b0, 1'b0);
    issue(1'b1, 32'h400, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd16, 2'd2, 1'b0, 3'd0, 6'd34);
    for (int k = 1; k < 5; k++) serve_load(32'h400 + 32'(4 * k), 32'hA0000000 + 32'(k));
    tick();

    // Misaligned word load and half store: no LSQ request, exception result.
    push(6'd22, 32'd0, 1'b0, 1'b1);
    issue(1'b1, 32'h100, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd2, 2'd2, 1'b0, 3'd0, 6'd22);
    check("mis_lw_noreq", {31'b0, lsq_req_valid}, 32'd0);
    tick();
    check("mis_lw_noreq2", {31'b0, lsq_req_valid}, 32'd0);
    push(6'd23, 32'd0, 1'b1, 1'b1);
    issue(1'b0, 32'h101, 1'b1, 6'd0, 32'h1234, 1'b1, 6'd0, 32'd0, 2'd1, 1'b0, 3'd2, 6'd23);
    check("mis_sh_noreq", {31'b0, lsq_req_valid}, 32'd0);
    tick(); tick();

    // Squash with head awaiting a response and three entries held.
    for (int k = 0; k < 3; k++)
      issue(1'b1, 32'h600, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'(4 * k), 2'd2, 1'b0, 3'd0, 6'(50 + k));
    wait_req("sq_req_wait");
    lsq_req_ready = 1'b1;
    tick();
    lsq_req_ready = 1'b0;
    squash = 1'b1; issue_valid = 1'b1; lsq_rsp_valid = 1'b1; lsq_rsp_data = 32'hBAD0BAD0;
    tick();
    squash = 1'b0; issue_valid = 1'b0; lsq_rsp_valid = 1'b0;
    check("sq_ready", {31'b0, issue_ready}, 32'd1);
    check("sq_req_valid", {31'b0, lsq_req_valid}, 32'd0);
    check("sq_res_valid", {31'b0, res_valid}, 32'd0);
    lsq_rsp_valid = 1'b1;
    tick();
    lsq_rsp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("sq_stray_res", {31'b0, res_valid}, 32'd0);
      check("sq_empty_req", {31'b0, lsq_req_valid}, 32'd0);
      tick();
    end
    do_load(6'd55, 32'h700, 32'd8, 2'd0, 1'b1, 32'h708, 32'h000000F1, 32'h000000F1);
    tick();

    // Reset in the middle of an outstanding request.
    issue(1'b1, 32'h800, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0, 2'd2, 1'b0, 3'd0, 6'd61);
    check("rm_req_valid", {31'b0, lsq_req_valid}, 32'd1);
    reset = 1'b1;
    tick();
    check("rm_req_valid0", {31'b0, lsq_req_valid}, 32'd0);
    check("rm_req_addr0", lsq_req_addr, 32'd0);
    check("rm_res_valid0", {31'b0, res_valid}, 32'd0);
    check("rm_res_tag0", {26'b0, res_tag}, 32'd0);
    check("rm_ready", {31'b0, issue_ready}, 32'd1);
    reset = 1'b0;
    tick();
    check("rm_after_req", {31'b0, lsq_req_valid}, 32'd0);
    do_load(6'd62, 32'h900, 32'd2, 2'd1, 1'b0, 32'h902, 32'h7FFF0000, 32'h00007FFF);
    tick(); tick();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
